// File: rtl/cordic_sincos_core_if.sv
// ---------------------------------------------------------------------------
// cordic_sincos_core_if
// Purpose : carries the 12-bit chip pin interface of the CORDIC core.
// Signals :
//   io_in  [9:0]  in_val, signed Q2.8 (angle in rotation, slope in vectoring)
//          [10]   mode (1 = rotation sin/cos, 0 = vectoring atan/magnitude)
//          [11]   out_sel (rotation 1=cos 0=sin; vectoring 1=atan 0=mag)
//   io_out [10:0] result, signed Q2.9 (zero whenever done is low)
//          [11]   done
// Handshake: level protocol, no valid/ready pair. The driver holds io_in
//   steady; done high means io_out[10:0] is valid for the input currently
//   held. Any change of io_in[10:0] drops done the next cycle and restarts
//   the computation. io_in[11] only steers the output mux.
// Modports: master = pin driver (bench/pad ring), slave = the core.
// ---------------------------------------------------------------------------
interface cordic_sincos_core_if;
    logic [11:0] io_in;
    logic [11:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);
endinterface

// File: rtl/cordic_sincos_core.sv
// ---------------------------------------------------------------------------
// cordic_sincos_core
// Purpose : iterative CORDIC engine. Rotation mode returns sin/cos of a Q2.8
//           angle; vectoring mode returns atan/magnitude of a Q2.8 slope.
//           One micro-rotation per clock, one result word per input set,
//           automatic restart whenever the input word changes.
// Ports   :
//   clock        in   single clock, all state on posedge
//   reset        in   synchronous, active-low
//   bus          slave modport of cordic_sincos_core_if (io_in / io_out)
//   o_dbg_state  out  current FSM state (0=LOAD, 1=RUN, 2=DONE)
// Latency : done rises ITER+2 clocks after the LOAD cycle
//           (1 load + ITER micro-rotations + 1 output register).
// ---------------------------------------------------------------------------
module cordic_sincos_core #(
    parameter int ITER = 12,    // micro-rotations, legal 10..14
    parameter int IW   = 16     // signed x/y/z width, 13 fraction bits
) (
    input  logic                  clock,
    input  logic                  reset,
    cordic_sincos_core_if.slave   bus,
    output logic [1:0]            o_dbg_state
);

    localparam int FRAC = 13;
    // Gain-compensation constant K = 0.607253 in Q.13
    localparam logic signed [31:0] K_Q13   = 32'sd4975;
    localparam logic signed [IW-1:0] ONE_Q13 = IW'(8192);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [10:0]           r_shadow;
    logic [3:0]            r_iter;
    logic signed [IW-1:0]  r_x;
    logic signed [IW-1:0]  r_y;
    logic signed [IW-1:0]  r_z;
    logic [11:0]           r_out;

    logic signed [9:0]     w_in_val;
    logic signed [9:0]     w_ang;
    logic signed [IW-1:0]  w_in_ext;
    logic signed [IW-1:0]  w_ang_ext;
    logic                  w_changed;
    logic                  w_d_pos;
    logic signed [IW-1:0]  w_xs;
    logic signed [IW-1:0]  w_ys;
    logic signed [IW-1:0]  w_atan;
    logic signed [31:0]    w_x32;
    logic signed [31:0]    w_y32;
    logic signed [31:0]    w_z32;
    logic signed [31:0]    w_prod;
    logic [10:0]           w_res1;
    logic [10:0]           w_res0;

    // atan(2^-i) in radians, Q.13
    function automatic logic signed [IW-1:0] atan_rom(input logic [3:0] i);
        case (i)
            4'd0:    return IW'(6434);
            4'd1:    return IW'(3798);
            4'd2:    return IW'(2007);
            4'd3:    return IW'(1019);
            4'd4:    return IW'(511);
            4'd5:    return IW'(256);
            4'd6:    return IW'(128);
            4'd7:    return IW'(64);
            4'd8:    return IW'(32);
            4'd9:    return IW'(16);
            4'd10:   return IW'(8);
            4'd11:   return IW'(4);
            4'd12:   return IW'(2);
            4'd13:   return IW'(1);
            default: return IW'(0);
        endcase
    endfunction

    // Clip a Q2.9 candidate to the 11-bit signed output range
    function automatic logic [10:0] sat11(input logic signed [31:0] v);
        if (v > 32'sd1023)
            return 11'h3FF;
        else if (v < -32'sd1024)
            return 11'h400;
        else
            return v[10:0];
    endfunction

    assign w_in_val  = bus.io_in[9:0];
    assign w_changed = (bus.io_in[10:0] != r_shadow);

    // Rotation input is limited to +-pi/2 so the CORDIC stays convergent
    always_comb begin
        w_ang = w_in_val;
        if (w_in_val > 10'sd402)
            w_ang = 10'sd402;
        else if (w_in_val < -10'sd402)
            w_ang = -10'sd402;
    end

    // Q2.8 -> Q.13: sign-extend then shift up by 5
    assign w_in_ext  = $signed({{(IW-10){w_in_val[9]}}, w_in_val}) <<< (FRAC - 8);
    assign w_ang_ext = $signed({{(IW-10){w_ang[9]}}, w_ang}) <<< (FRAC - 8);

    // d = +1 when w_d_pos. Rotation drives z to 0 (d=sign z),
    // vectoring drives y to 0 (d=-sign y).
    assign w_d_pos = r_shadow[10] ? ~r_z[IW-1] : r_y[IW-1];
    assign w_xs    = r_x >>> r_iter;
    assign w_ys    = r_y >>> r_iter;
    assign w_atan  = atan_rom(r_iter);

    // Results: round-half-up from Q.13 to Q.9, then saturate
    assign w_x32  = $signed({{(32-IW){r_x[IW-1]}}, r_x});
    assign w_y32  = $signed({{(32-IW){r_y[IW-1]}}, r_y});
    assign w_z32  = $signed({{(32-IW){r_z[IW-1]}}, r_z});
    // Magnitude carries the CORDIC gain; x*K is Q.26, round once to Q.9
    assign w_prod = w_x32 * K_Q13;

    always_comb begin
        if (r_shadow[10]) begin
            w_res1 = sat11((w_x32 + 32'sd8) >>> (FRAC - 9));   // cos
            w_res0 = sat11((w_y32 + 32'sd8) >>> (FRAC - 9));   // sin
        end else begin
            w_res1 = sat11((w_z32 + 32'sd8) >>> (FRAC - 9));   // atan
            w_res0 = sat11((w_prod + 32'sd65536) >>> (2*FRAC - 9)); // mag
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_LOAD;
            r_out   <= '0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_shadow <= bus.io_in[10:0];
                    r_iter   <= '0;
                    r_out    <= '0;
                    if (bus.io_in[10]) begin
                        r_x <= IW'(K_Q13);
                        r_y <= '0;
                        r_z <= w_ang_ext;
                    end else begin
                        r_x <= ONE_Q13;
                        r_y <= w_in_ext;
                        r_z <= '0;
                    end
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_out <= '0;
                    if (w_changed) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_x    <= w_d_pos ? (r_x - w_ys)   : (r_x + w_ys);
                        r_y    <= w_d_pos ? (r_y + w_xs)   : (r_y - w_xs);
                        r_z    <= w_d_pos ? (r_z - w_atan) : (r_z + w_atan);
                        r_iter <= r_iter + 4'd1;
                        if (r_iter == 4'(ITER - 1))
                            r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // x/y/z are frozen here; out_sel only re-muxes them
                    if (w_changed) begin
                        r_out   <= '0;
                        r_state <= S_LOAD;
                    end else begin
                        r_out <= {1'b1, (bus.io_in[11] ? w_res1 : w_res0)};
                    end
                end
                default: begin
                    r_out   <= '0;
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign bus.io_out  = r_out;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cordic_sincos_core.sv
// ---------------------------------------------------------------------------
// tb_cordic_sincos_core
// Drives the pin interface, keeps an ideal-math model (real sin/cos/atan/sqrt)
// as the source of expected results, and checks latency, zero-while-busy,
// reset behaviour and result accuracy (+-2 LSB).
// ---------------------------------------------------------------------------
module tb_cordic_sincos_core;

    logic       clock;
    logic       reset;
    logic [1:0] dbg_state;

    cordic_sincos_core_if bus_if();

    cordic_sincos_core #(.ITER(12), .IW(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [10:0] exp_q[$];
    int          cur_v;
    bit          cur_mode;

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        int diff;
        diff = obs - exp;
        n_cmp++;
        if (diff > tol || diff < -tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Ideal result scaled to Q2.9, rounded to nearest, clipped to 11 bits
    function automatic int ideal(input int v, input bit mode, input bit sel);
        real a;
        real r;
        int  c;
        int  res;
        c = v;
        if (mode) begin
            if (c > 402)  c = 402;
            if (c < -402) c = -402;
            a = real'(c) / 256.0;
            r = sel ? $cos(a) : $sin(a);
        end else begin
            a = real'(v) / 256.0;
            r = sel ? $atan(a) : $sqrt(1.0 + a * a);
        end
        r = r * 512.0;
        res = $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
        if (res > 1023)  res = 1023;
        if (res < -1024) res = -1024;
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input int v, input bit mode, input bit sel);
        logic [9:0] v10;
        v10 = 10'(v);
        bus_if.io_in = {sel, mode, v10};
        cur_v    = v;
        cur_mode = mode;
    endtask

    task automatic push_exp(input int v, input bit mode, input bit sel);
        exp_q.push_back(11'(ideal(v, mode, sel)));
    endtask

    task automatic pop_check(input string tag);
        logic signed [10:0] e;
        logic signed [10:0] o;
        if (exp_q.size() == 0) begin
            check({tag, "_sb"}, exp_q.size(), 1, 0);
        end else begin
            e = exp_q.pop_front();
            o = bus_if.io_out[10:0];
            check({tag, "_done"}, int'(bus_if.io_out[11]), 1, 0);
            check(tag, int'(o), int'(e), 2);
        end
    endtask

    // Counts clocks until done, checking the result stays 0 while busy
    task automatic wait_done(input string tag, input int lat);
        int n;
        int leak;
        bit seen;
        n = 0; leak = 0; seen = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (bus_if.io_out[11])
                seen = 1;
            else if (bus_if.io_out[10:0] != 11'd0)
                leak++;
        end
        check({tag, "_lat"}, n, lat, 0);
        check({tag, "_zero"}, leak, 0, 0);
        pop_check(tag);
    endtask

    task automatic run(input string tag, input int v, input bit mode, input bit sel, input int lat);
        set_in(v, mode, sel);
        push_exp(v, mode, sel);
        wait_done(tag, lat);
    endtask

    task automatic sel_step(input string tag, input bit sel);
        bus_if.io_in[11] = sel;
        push_exp(cur_v, cur_mode, sel);
        tick();
        pop_check(tag);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  leak;
        int  rv;
        bit  rm;
        bit  rs;

        reset = 1'b0;
        set_in(0, 1'b1, 1'b1);
        push_exp(0, 1'b1, 1'b1);

        // Reset held low for three clocks
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out", int'(bus_if.io_out), 0, 0);
        end
        check("rst_state", int'(dbg_state), 0, 0);
        reset = 1'b1;
        wait_done("cos0", 14);

        // pi/6, then out_sel flip without recompute
        run("sin30", 134, 1'b1, 1'b0, 15);
        sel_step("cos30", 1'b1);
        for (int i = 0; i < 3; i++) begin
            push_exp(134, 1'b1, 1'b1);
            tick();
            pop_check("cos30_held");
        end
        sel_step("sin30_back", 1'b0);

        // Boundary angles and clamping
        run("sin_m90", -402, 1'b1, 1'b0, 15);
        sel_step("cos_m90", 1'b1);
        run("sin_clamp", 511, 1'b1, 1'b0, 15);
        sel_step("cos_clamp", 1'b1);

        // Vectoring
        run("atan1", 256, 1'b0, 1'b1, 15);
        sel_step("mag1", 1'b0);
        run("mag0", 0, 1'b0, 1'b0, 15);
        sel_step("atan0", 1'b1);
        run("atan_neg", -300, 1'b0, 1'b1, 15);
        sel_step("mag_neg", 1'b0);

        // Random inputs kept inside +-500 so the following fixed cases always differ
        for (int k = 0; k < 6; k++) begin
            rv = int'($urandom_range(0, 1000)) - 500;
            rm = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            if (rv == cur_v && rm == cur_mode)
                rv = rv ^ 1;
            run("rand", rv, rm, rs, 15);
            sel_step("rand_sel", ~rs);
        end

        // Magnitude saturation
        run("mag_sat", 511, 1'b0, 1'b0, 15);
        run("mag_satn", -512, 1'b0, 1'b0, 15);

        // Input change in the middle of RUN (after 5 micro-rotations)
        set_in(0, 1'b1, 1'b0);
        leak = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus_if.io_out != 12'd0)
                leak++;
        end
        check("pre_abort_quiet", leak, 0, 0);
        check("pre_abort_state", int'(dbg_state), 1, 0);
        run("restart_run", 134, 1'b1, 1'b0, 15);

        // Reset in the middle of RUN
        set_in(-134, 1'b1, 1'b0);
        push_exp(-134, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            tick();
        reset = 1'b0;
        tick();
        check("rst_run_out", int'(bus_if.io_out), 0, 0);
        check("rst_run_state", int'(dbg_state), 0, 0);
        reset = 1'b1;
        wait_done("after_rst_run", 14);

        // Reset while a result is being presented
        reset = 1'b0;
        tick();
        check("rst_done_out", int'(bus_if.io_out), 0, 0);
        reset = 1'b1;
        push_exp(-134, 1'b1, 1'b0);
        wait_done("after_rst_done", 14);

        check("sb_empty", exp_q.size(), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
